// File: rtl/flood_pkg.sv
// Shared parameters, checker state encoding and board-size clamping for the flood-it win checker.
package flood_pkg;

  localparam int unsigned MAX_SIZE = 26;
  localparam int unsigned COORD_W  = 5;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned CNT_W    = 7;

  localparam logic [COORD_W-1:0] MIN_SIZE = COORD_W'(2);
  localparam logic [COORD_W-1:0] TOP_SIZE = COORD_W'(MAX_SIZE);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SCAN,
    REPORT
  } chk_state_t;

  function automatic logic [COORD_W-1:0] clamp_size(input logic [COORD_W-1:0] size);
    if (size < MIN_SIZE) begin
      return MIN_SIZE;
    end
    if (size > TOP_SIZE) begin
      return TOP_SIZE;
    end
    return size;
  endfunction

endpackage

// File: rtl/flood_win_checker_if.sv
// Game-logic / board / score-stage signals seen by the win checker.
interface flood_win_checker_if;
  import flood_pkg::*;

  logic [COORD_W-1:0] BOARD_SIZE;
  logic [CNT_W-1:0]   MOVE_LIMIT;
  logic               ACK_BEGIN_GAME;
  logic               CHANGING_COLOR;
  logic [COORD_W-1:0] RD_ROW;
  logic [COORD_W-1:0] RD_COL;
  logic [COLOR_W-1:0] RD_COLOR;
  logic [CNT_W-1:0]   MOVE_COUNT;
  logic               CHECK_BUSY;
  logic               CHECK_DONE;
  logic               GAME_WON;
  logic               GAME_LOST;

  // Game side: drives game control and the board read data, observes the verdict.
  modport master (
    output BOARD_SIZE, MOVE_LIMIT, ACK_BEGIN_GAME, CHANGING_COLOR, RD_COLOR,
    input  RD_ROW, RD_COL, MOVE_COUNT, CHECK_BUSY, CHECK_DONE, GAME_WON, GAME_LOST
  );

  // Checker side.
  modport slave (
    input  BOARD_SIZE, MOVE_LIMIT, ACK_BEGIN_GAME, CHANGING_COLOR, RD_COLOR,
    output RD_ROW, RD_COL, MOVE_COUNT, CHECK_BUSY, CHECK_DONE, GAME_WON, GAME_LOST
  );

endinterface

// File: rtl/board_raster_addr.sv
// Row-major raster address generator over a size x size board with clear, advance and last flag.
module board_raster_addr
  import flood_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] size,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last
);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] edge_idx;
  logic               col_end;

  assign edge_idx = size - COORD_W'(1);
  assign col_end  = (col_q == edge_idx);
  assign last     = col_end && (row_q == edge_idx);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (last) begin
        // Wrap to the origin so a free-running consumer can sweep repeatedly.
        row_d = '0;
        col_d = '0;
      end else if (col_end) begin
        row_d = row_q + COORD_W'(1);
        col_d = '0;
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/flood_win_checker.sv
// Counts completed recolour moves and raster-scans the board after each to flag a win or a loss.
module flood_win_checker
  import flood_pkg::*;
(
  input  logic                CLOCK,
  input  logic                RESET_N,
  flood_win_checker_if.slave  bus
);

  chk_state_t         state_q, state_d;
  logic               chg_q;
  logic               move_done;
  logic               start;
  logic               accept;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               won_q, won_d;
  logic               lost_q, lost_d;
  logic [COORD_W-1:0] size_q, size_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [COLOR_W-1:0] ref_q, ref_d;
  logic               addr_clear;
  logic               addr_advance;
  logic               addr_last;
  logic [COORD_W-1:0] addr_row;
  logic [COORD_W-1:0] addr_col;
  logic               mismatch;
  logic               verdict;
  logic               uniform;

  assign start     = bus.ACK_BEGIN_GAME;
  assign move_done = chg_q & ~bus.CHANGING_COLOR;
  assign accept    = move_done & ~won_q & ~lost_q;
  assign mismatch  = (bus.RD_COLOR != ref_q);

  board_raster_addr u_addr (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .size    (size_q),
    .clear   (addr_clear),
    .advance (addr_advance),
    .row     (addr_row),
    .col     (addr_col),
    .last    (addr_last)
  );

  // Scan sequencing; game start overrides everything, a new move restarts the scan.
  always_comb begin
    state_d      = state_q;
    addr_clear   = 1'b0;
    addr_advance = 1'b0;
    verdict      = 1'b0;
    uniform      = 1'b0;
    ref_d        = ref_q;

    unique case (state_q)
      IDLE: begin
      end
      CAPTURE: begin
        ref_d        = bus.RD_COLOR;
        addr_advance = 1'b1;
        state_d      = SCAN;
      end
      SCAN: begin
        if (mismatch) begin
          // A differing cell settles the verdict in the cycle it is seen.
          verdict = 1'b1;
          state_d = IDLE;
        end else if (addr_last) begin
          state_d = REPORT;
        end else begin
          addr_advance = 1'b1;
        end
      end
      REPORT: begin
        verdict = 1'b1;
        uniform = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d      = CAPTURE;
      addr_clear   = 1'b1;
      addr_advance = 1'b0;
    end

    if (start) begin
      state_d      = IDLE;
      addr_clear   = 1'b0;
      addr_advance = 1'b0;
      verdict      = 1'b0;
      uniform      = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    won_d   = won_q;
    lost_d  = lost_q;
    size_d  = size_q;
    limit_d = limit_q;

    if (start) begin
      count_d = '0;
      won_d   = 1'b0;
      lost_d  = 1'b0;
      size_d  = clamp_size(bus.BOARD_SIZE);
      limit_d = bus.MOVE_LIMIT;
    end else begin
      if (accept && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (verdict) begin
        if (uniform) begin
          won_d = 1'b1;
        end else if (count_q >= limit_q) begin
          lost_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      chg_q   <= 1'b0;
      count_q <= '0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
      size_q  <= MIN_SIZE;
      limit_q <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      chg_q   <= bus.CHANGING_COLOR;
      count_q <= count_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
      size_q  <= size_d;
      limit_q <= limit_d;
      ref_q   <= ref_d;
    end
  end

  assign bus.RD_ROW     = addr_row;
  assign bus.RD_COL     = addr_col;
  assign bus.MOVE_COUNT = count_q;
  assign bus.CHECK_BUSY = (state_q == CAPTURE) || (state_q == SCAN);
  assign bus.CHECK_DONE = verdict;
  assign bus.GAME_WON   = won_q;
  assign bus.GAME_LOST  = lost_q;

endmodule

// File: tb/tb_flood_win_checker.sv
// Bench for flood_win_checker: directed vector table, hand sequences and a randomized model check.
module tb_flood_win_checker;
  import flood_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  flood_win_checker_if bus ();

  flood_win_checker dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  logic [COLOR_W-1:0] board [MAX_SIZE][MAX_SIZE];

  always_comb begin
    bus.RD_COLOR = '0;
    if (int'(bus.RD_ROW) < MAX_SIZE && int'(bus.RD_COL) < MAX_SIZE) begin
      bus.RD_COLOR = board[int'(bus.RD_ROW)][int'(bus.RD_COL)];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference game state
  int m_size;
  int m_limit;
  int m_count;
  bit m_won;
  bit m_lost;

  typedef struct {
    int bs;
    int lim;
    bit diff;
    int dr;
    int dc;
    int lat;
    int won;
    int lost;
    int erow;
    int ecol;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input logic [COLOR_W-1:0] c);
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int q = 0; q < MAX_SIZE; q++) begin
        board[r][q] = c;
      end
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < m_size * m_size; i++) begin
      if (board[i / m_size][i % m_size] != board[0][0]) return i;
    end
    return -1;
  endfunction

  task automatic start_game(input int bs, input int lim);
    bus.BOARD_SIZE     = COORD_W'(bs);
    bus.MOVE_LIMIT     = CNT_W'(lim);
    bus.ACK_BEGIN_GAME = 1'b1;
    @(negedge clk);
    bus.ACK_BEGIN_GAME = 1'b0;
    m_size  = (bs < 2) ? 2 : ((bs > int'(MAX_SIZE)) ? int'(MAX_SIZE) : bs);
    m_limit = lim;
    m_count = 0;
    m_won   = 1'b0;
    m_lost  = 1'b0;
  endtask

  // One CHANGING_COLOR pulse; lat counts cycles after move_done until CHECK_DONE (-1 on timeout).
  task automatic pulse_move(output int lat);
    bus.CHANGING_COLOR = 1'b1;
    @(negedge clk);
    bus.CHANGING_COLOR = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.CHECK_DONE === 1'b1) break;
      if (lat >= 2000) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic do_move_checked(input string tag);
    int  k;
    int  exp_lat;
    int  lat;
    bit  seen;
    if (m_won || m_lost) begin
      bus.CHANGING_COLOR = 1'b1;
      @(negedge clk);
      bus.CHANGING_COLOR = 1'b0;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (bus.CHECK_BUSY !== 1'b0 || bus.CHECK_DONE !== 1'b0) seen = 1'b1;
      end
      check({tag, " no scan"}, 32'(seen), 32'd0);
    end else begin
      if (m_count < 127) m_count++;
      k = first_diff();
      if (k < 0) begin
        exp_lat = m_size * m_size + 1;
        m_won   = 1'b1;
      end else begin
        exp_lat = k + 1;
        if (m_count >= m_limit) m_lost = 1'b1;
      end
      pulse_move(lat);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
    end
    check({tag, " count"}, 32'(bus.MOVE_COUNT), 32'(m_count));
    check({tag, " won"}, 32'(bus.GAME_WON), 32'(m_won));
    check({tag, " lost"}, 32'(bus.GAME_LOST), 32'(m_lost));
  endtask

  initial begin
    int lat;
    int mode;
    int seen;

    bus.BOARD_SIZE     = '0;
    bus.MOVE_LIMIT     = '0;
    bus.ACK_BEGIN_GAME = 1'b0;
    bus.CHANGING_COLOR = 1'b0;
    fill(3'd5);

    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset row", 32'(bus.RD_ROW), 32'd0);
    check("reset col", 32'(bus.RD_COL), 32'd0);
    check("reset count", 32'(bus.MOVE_COUNT), 32'd0);
    check("reset busy", 32'(bus.CHECK_BUSY), 32'd0);
    check("reset done", 32'(bus.CHECK_DONE), 32'd0);
    check("reset won", 32'(bus.GAME_WON), 32'd0);
    check("reset lost", 32'(bus.GAME_LOST), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // bs, lim, diff, dr, dc, lat, won, lost, final row, final col
    vecs[0] = '{2,  5,  1'b0, 0,  0,  5,   1, 0, 1,  1};
    vecs[1] = '{6,  10, 1'b1, 0,  3,  4,   0, 0, 0,  3};
    vecs[2] = '{31, 5,  1'b0, 0,  0,  677, 1, 0, 25, 25};
    vecs[3] = '{0,  0,  1'b1, 1,  1,  4,   0, 1, 1,  1};
    vecs[4] = '{3,  1,  1'b1, 2,  2,  9,   0, 1, 2,  2};
    vecs[5] = '{4,  9,  1'b1, 1,  0,  5,   0, 0, 1,  0};
    vecs[6] = '{26, 3,  1'b1, 25, 25, 676, 0, 0, 25, 25};

    for (int i = 0; i < 7; i++) begin
      start_game(vecs[i].bs, vecs[i].lim);
      fill(3'd5);
      if (vecs[i].diff) board[vecs[i].dr][vecs[i].dc] = 3'd2;
      pulse_move(lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d won", i), 32'(bus.GAME_WON), 32'(vecs[i].won));
      check($sformatf("vec%0d lost", i), 32'(bus.GAME_LOST), 32'(vecs[i].lost));
      check($sformatf("vec%0d count", i), 32'(bus.MOVE_COUNT), 32'd1);
      check($sformatf("vec%0d row", i), 32'(bus.RD_ROW), 32'(vecs[i].erow));
      check($sformatf("vec%0d col", i), 32'(bus.RD_COL), 32'(vecs[i].ecol));
    end

    // Loss on the third move, fourth move ignored
    start_game(3, 3);
    fill(3'd1);
    board[0][1] = 3'd4;
    for (int i = 0; i < 4; i++) do_move_checked($sformatf("limit3 move%0d", i + 1));
    check("limit3 lost flag", 32'(bus.GAME_LOST), 32'd1);
    check("limit3 count held", 32'(bus.MOVE_COUNT), 32'd3);

    // Win on the final allowed move beats loss
    start_game(4, 2);
    fill(3'd6);
    board[3][1] = 3'd0;
    do_move_checked("limit2 move1");
    fill(3'd0);
    do_move_checked("limit2 move2");
    check("limit2 won", 32'(bus.GAME_WON), 32'd1);
    check("limit2 not lost", 32'(bus.GAME_LOST), 32'd0);

    // Game start aborts a running scan
    start_game(6, 10);
    fill(3'd3);
    bus.CHANGING_COLOR = 1'b1;
    @(negedge clk);
    bus.CHANGING_COLOR = 1'b0;
    repeat (5) @(negedge clk);
    check("ack busy before", 32'(bus.CHECK_BUSY), 32'd1);
    bus.ACK_BEGIN_GAME = 1'b1;
    @(negedge clk);
    bus.ACK_BEGIN_GAME = 1'b0;
    check("ack busy after", 32'(bus.CHECK_BUSY), 32'd0);
    check("ack count", 32'(bus.MOVE_COUNT), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.CHECK_DONE !== 1'b0 || bus.GAME_WON !== 1'b0) seen = 1;
    end
    check("ack no done", 32'(seen), 32'd0);
    m_count = 0;

    // Reset aborts a running scan immediately
    start_game(6, 10);
    fill(3'd3);
    bus.CHANGING_COLOR = 1'b1;
    @(negedge clk);
    bus.CHANGING_COLOR = 1'b0;
    repeat (8) @(negedge clk);
    check("rst busy before", 32'(bus.CHECK_BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy after", 32'(bus.CHECK_BUSY), 32'd0);
    check("rst count", 32'(bus.MOVE_COUNT), 32'd0);
    check("rst row", 32'(bus.RD_ROW), 32'd0);
    check("rst col", 32'(bus.RD_COL), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.CHECK_DONE !== 1'b0 || bus.GAME_WON !== 1'b0) seen = 1;
    end
    check("rst no done", 32'(seen), 32'd0);

    // Randomized games against the reference model
    for (int it = 0; it < 60; it++) begin
      if (it % 5 == 0) start_game(int'($urandom_range(0, 10)), int'($urandom_range(0, 4)));
      fill(COLOR_W'($urandom_range(0, 7)));
      mode = int'($urandom_range(0, 2));
      if (mode == 1) begin
        int r;
        int c;
        r = int'($urandom_range(0, m_size - 1));
        c = int'($urandom_range(0, m_size - 1));
        board[r][c] = board[r][c] ^ 3'd1;
      end else if (mode == 2) begin
        for (int r = 0; r < m_size; r++) begin
          for (int c = 0; c < m_size; c++) board[r][c] = COLOR_W'($urandom_range(0, 1));
        end
      end
      do_move_checked($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
